// File: rtl/led_pkg.sv
// Shared definitions for the LED frame scheduler.
// Holds the FSM state encoding, the default chain geometry and a small helper
// that sizes counters so a divide-by-one configuration still gets a 1-bit
// counter instead of a zero-width vector.
package led_pkg;

    typedef logic [1:0] led_state_t;

    localparam led_state_t ST_IDLE  = 2'd0;
    localparam led_state_t ST_LOAD  = 2'd1;
    localparam led_state_t ST_SHIFT = 2'd2;
    localparam led_state_t ST_LATCH = 2'd3;

    localparam int LED_WIDTH       = 16;
    localparam int LED_DIV_DEFAULT = 4;

    // Width of a counter that must hold the values 0..n-1 (minimum 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_rr_arb2.sv
// Two-input round-robin arbiter.
// Grants whichever request is high; on a tie it grants the input that did not
// win last time. The "last winner" pointer only moves when the consumer
// signals that it actually took a grant.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   req0, req1       request inputs
//   accept           strobe: the consumer took the grant identified by accept_id
//   accept_id        which input was taken
//   grant_valid      at least one request is pending
//   grant_sel        input that would be granted this cycle
module led_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    input  logic accept_id,
    output logic grant_valid,
    output logic grant_sel
);

    logic last_id;

    // Resetting the pointer to 1 makes input 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (accept) begin
            last_id <= accept_id;
        end
    end

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_sel = ~last_id;
        end else begin
            grant_sel = req1;
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Frame sequencer and arbiter for a 74HC164-style serial LED chain.
// Two requesters hand over frames with a req/ack handshake; the winner's frame
// is captured, optionally inverted, shifted out MSB-first with a divided serial
// clock while the chain is blanked, then latched and shown.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   req0/data0/ack0      requester 0 handshake and frame
//   req1/data1/ack1      requester 1 handshake and frame
//   busy                 a frame is in flight (LOAD through LATCH)
//   done                 one-cycle pulse on the last LATCH cycle
//   grant_id             source of the current/last frame
//   led_clk, led_do      serial clock and data to the chain
//   led_pen              chain output enable (1 = shown)
//   led_clr              chain clear, active-low
module led_frame_sched
    import led_pkg::*;
#(
    parameter int WIDTH  = LED_WIDTH,
    parameter int DIV    = LED_DIV_DEFAULT,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             grant_id,
    output logic             led_clk,
    output logic             led_do,
    output logic             led_pen,
    output logic             led_clr
);

    localparam int DW = cnt_width(DIV);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    led_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             phase;
    logic             pen_q;
    logic             clr_q;
    logic             gid_q;

    logic             arb_valid;
    logic             arb_sel;
    logic [WIDTH-1:0] frame_data;
    logic [WIDTH-1:0] load_data;
    logic             div_end;

    led_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .accept      (state == ST_LOAD),
        .accept_id   (gid_q),
        .grant_valid (arb_valid),
        .grant_sel   (arb_sel)
    );

    always_comb begin
        frame_data = gid_q ? data1 : data0;
        load_data  = (INVERT != 0) ? ~frame_data : frame_data;
        div_end    = (div_cnt == DIV_LAST);
    end

    // Main sequencer. The grant is registered on the way into LOAD so that the
    // ack and grant_id are visible during LOAD, while the frame data itself is
    // sampled only at the end of LOAD. Within SHIFT, phase=0 is the low half
    // and phase=1 the high half of the serial clock; the shift register only
    // moves at the end of a high half so led_do changes while led_clk is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            pen_q   <= 1'b0;
            clr_q   <= 1'b0;
            gid_q   <= 1'b0;
        end else begin
            clr_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state <= ST_LOAD;
                        gid_q <= arb_sel;
                        pen_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    shreg   <= load_data;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_LATCH;
                                pen_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        ack0     = (state == ST_LOAD) && !gid_q;
        ack1     = (state == ST_LOAD) && gid_q;
        busy     = (state != ST_IDLE);
        done     = (state == ST_LATCH) && div_end;
        grant_id = gid_q;
        led_clk  = (state == ST_SHIFT) && phase;
        led_do   = (state == ST_SHIFT) && shreg[WIDTH-1];
        led_pen  = pen_q;
        led_clr  = clr_q;
    end

endmodule
